// File: rtl/scan_seq_detector.sv
// Parametrised serial pattern detector (KMP next-state table built at elaboration)
// with a saturating match counter; every flop sits on one scan chain.
module scan_seq_detector #(
   parameter int                  PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0]  PATTERN = 4'b1011,
   parameter int                  OVERLAP = 1,
   parameter int                  CNT_W   = 4,
   parameter int                  SW      = $clog2(PAT_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scan_enable,
   input  logic             scan_in,
   output logic             scan_out,
   input  logic             en,
   input  logic             clr,
   input  logic             inp,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int               NUM_ST   = 2 ** SW;
   localparam int               TBL_W    = 2 * NUM_ST * SW;
   localparam int               CHAIN_W  = SW + CNT_W;
   localparam logic [SW-1:0]    ST_MATCH = SW'(PAT_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Entry (s, b) holds the next state from state s on input bit b, SW bits wide.
   function automatic logic [TBL_W-1:0] build_tbl();
      logic [TBL_W-1:0] t;
      logic             ch;
      logic             ok;
      int               border;
      int               eff;
      int               best;
      int               pos;
      t      = '0;
      border = 0;
      for (int k = 1; k < PAT_LEN; k++) begin
         ok = 1'b1;
         for (int j = 0; j < k; j++) begin
            if (PATTERN[PAT_LEN-1-j] != PATTERN[k-1-j]) ok = 1'b0;
         end
         if (ok) border = k;
      end
      for (int s = 0; s < NUM_ST; s++) begin
         for (int b = 0; b < 2; b++) begin
            if (s < PAT_LEN)       eff = s;
            else if (s == PAT_LEN) eff = (OVERLAP != 0) ? border : 0;
            else                   eff = 0;
            // Longest suffix of (matched prefix, b) that is also a pattern prefix.
            best = 0;
            for (int k = 1; k <= eff + 1; k++) begin
               ok = 1'b1;
               for (int j = 0; j < k; j++) begin
                  pos = eff + 1 - k + j;
                  ch  = (pos < eff) ? PATTERN[PAT_LEN-1-pos] : b[0];
                  if (ch != PATTERN[PAT_LEN-1-j]) ok = 1'b0;
               end
               if (ok) best = k;
            end
            t[(s*2+b)*SW +: SW] = best[SW-1:0];
         end
      end
      return t;
   endfunction

   localparam logic [TBL_W-1:0] NXT_TBL = build_tbl();

   logic [SW-1:0]      r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [SW-1:0]      w_next;
   logic [CHAIN_W-1:0] w_chain;

   // Next-state lookup and scan chain view of all flops.
   always_comb begin
      w_next  = NXT_TBL[(int'({r_state, inp}) * SW) +: SW];
      w_chain = {r_cnt, r_state};
   end

   // State and counter: reset, scan shift, or functional update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= '0;
         r_cnt   <= '0;
      end else if (scan_enable) begin
         {r_cnt, r_state} <= {w_chain[CHAIN_W-2:0], scan_in};
      end else begin
         if (en) r_state <= w_next;
         else    r_state <= r_state;
         if (clr)
            r_cnt <= '0;
         else if (en && (w_next == ST_MATCH) && (r_cnt != CNT_MAX))
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         else
            r_cnt <= r_cnt;
      end
   end

   assign out       = (r_state == ST_MATCH);
   assign match_cnt = r_cnt;
   assign scan_out  = r_cnt[CNT_W-1];

endmodule
